vga_sync_gen: RTL and testbench
===============================

# vga_sync_gen

Timing generator for the VGA path. Runs off the 25 MHz pixel clock and produces the raster position (`pixel_x`, `pixel_y`), the `video_on` qualifier and the horizontal and vertical sync pulses. It sits directly upstream of the renderer, which consumes `pixel_x`, `pixel_y` and `video_on`. Sync outputs are delayed to line up with the renderer's one-cycle registered colour outputs at the connector.

## Interface
- `H_VIDEO`, 640: active pixels per line
- `H_FRONT`, 16: horizontal front porch, in pixels
- `H_SYNC`, 96: hsync pulse width, in pixels
- `H_BACK`, 48: horizontal back porch, in pixels
- `V_VIDEO`, 480: active lines per frame
- `V_FRONT`, 10: vertical front porch, in lines
- `V_SYNC`, 2: vsync pulse width, in lines
- `V_BACK`, 33: vertical back porch, in lines
- `SYNC_POL`, 0: active level of hsync/vsync (0 = active-low)
- `SYNC_DELAY`, 1: cycles of delay applied to hsync/vsync, range 0–4
- `clk_0`  in  1  25 MHz pixel clock
- `rst`  in  1  reset; asynchronous assert, active-low
- `pixel_x`  out  10  horizontal position, 0..H_TOTAL-1
- `pixel_y`  out  10  vertical position, 0..V_TOTAL-1
- `video_on`  out  1  high when the position is in the active area
- `line_start`  out  1  one-cycle pulse when `pixel_x` becomes 0
- `frame_start`  out  1  one-cycle pulse when the position becomes (0,0)
- `frame_count`  out  8  completed-frame counter, wraps
- `hsync`  out  1  horizontal sync, delayed by SYNC_DELAY
- `vsync`  out  1  vertical sync, delayed by SYNC_DELAY

## Operation
- Derived totals: H_TOTAL = sum of the H_* parameters (800); V_TOTAL = sum of the V_* parameters (525).
- Horizontal FSM states: H_ACTIVE (x < 640), H_FRONT (640..655), H_SYNC (656..751), H_BACK (752..799).
  - Each state transitions in order when x reaches its last value.
  - H_BACK returns to H_ACTIVE with x = 0.
- Vertical FSM states: V_ACTIVE (y < 480), V_FRONT (480..489), V_SYNC (490..491), V_BACK (492..524).
  - The vertical FSM advances only on the cycle where x wraps from 799 to 0.
  - y wraps from 524 to 0.
- All outputs are registered decodes of the new position. Every output changes on the same edge as `pixel_x` and `pixel_y`.
- `video_on` = (H_ACTIVE and V_ACTIVE).
- Raw sync is active while in H_SYNC (for hsync) or V_SYNC (for vsync), driven at level SYNC_POL. Raw sync passes through a SYNC_DELAY-deep shift register before reaching `hsync`/`vsync`.
- `frame_count` increments by 1 on the edge where `frame_start` is asserted. It wraps from 255 to 0.
- The counters are 10 bits wide. Compares use H_TOTAL-1 and V_TOTAL-1, so counters never pass those values.

## Timing
- Reset position is (799, 524), the last pixel of the frame. Reset output values:
  - `pixel_x` = 799, `pixel_y` = 524
  - `video_on` = 0, `line_start` = 0, `frame_start` = 0
  - `frame_count` = 0
  - `hsync` = `vsync` = inactive (!SYNC_POL); every stage of the delay shift register is inactive
- First rising edge after `rst` deasserts: position (0,0), `video_on` = 1, `line_start` = 1, `frame_start` = 1, `frame_count` = 1.
- Position advances by one every cycle. There is no stall and no enable.
- Line period is 800 cycles. Frame period is 420 000 cycles.
- The renderer's colour output for position p appears one cycle after p is presented. With SYNC_DELAY = 1, `hsync` goes active on the edge after `pixel_x` becomes 656 and stays active for exactly 96 cycles.
- `vsync` changes only at line boundaries, delayed by SYNC_DELAY cycles relative to the `pixel_x` 799→0 edge.
- Reset asserted mid-frame: all state, including the sync delay pipe, returns to reset values asynchronously, with no glitch to active sync. On release, operation restarts at (0,0).
- SYNC_DELAY = 0: `hsync`/`vsync` are combinational from the FSM state registers, so they are still glitch-free.

## Test plan
- Reset check: hold `rst` low for 10 cycles → `pixel_x` = 799, `pixel_y` = 524, `video_on` = 0, `hsync` = `vsync` = 1, `frame_count` = 0. First edge after release → (0,0), `video_on` = 1, `frame_start` = 1.
- Line timing: track one line → `video_on` is high for exactly 640 cycles. `hsync` is low for 96 cycles, going low 657 cycles after `line_start` (SYNC_DELAY = 1). `line_start` pulses repeat every 800 cycles.
- Frame timing: run 2 frames → `frame_start` pulses exactly 420 000 cycles apart. `video_on` is high for 307 200 cycles per frame. `vsync` is low for 1600 cycles, starting at the line where `pixel_y` = 490.
- Wrap: observe (799, 479) → (0, 480) with `video_on` = 0. Observe (799, 524) → (0, 0) with `frame_start` = 1.
- `frame_count`: run 256 frames (force or accelerate with small parameters, e.g. H_TOTAL = 8, V_TOTAL = 6) → `frame_count` reads 255 and then wraps to 0.
- Mid-operation reset: assert `rst` at position (700, 491) while `vsync` is active → `vsync` = `hsync` = 1 immediately, without waiting for a clock edge. After release, the sequence matches the reset-check scenario.

Source files
------------

// File: rtl/vga_sync_gen.sv
// VGA raster timing generator: position, video_on qualifier, line/frame pulses, sync.
// Latency: position and decodes registered together; sync trails its state by SYNC_DELAY cycles.
// No backpressure: free-running, advances one pixel per clk_0 cycle with no stall or enable.
module vga_sync_gen #(
   parameter int H_VIDEO    = 640,
   parameter int H_FRONT    = 16,
   parameter int H_SYNC     = 96,
   parameter int H_BACK     = 48,
   parameter int V_VIDEO    = 480,
   parameter int V_FRONT    = 10,
   parameter int V_SYNC     = 2,
   parameter int V_BACK     = 33,
   parameter int SYNC_POL   = 0,
   parameter int SYNC_DELAY = 1
) (
   input  logic       clk_0,
   input  logic       rst,
   output logic [9:0] pixel_x,
   output logic [9:0] pixel_y,
   output logic       video_on,
   output logic       line_start,
   output logic       frame_start,
   output logic [7:0] frame_count,
   output logic       hsync,
   output logic       vsync
);

   localparam int H_TOTAL = H_VIDEO + H_FRONT + H_SYNC + H_BACK;
   localparam int V_TOTAL = V_VIDEO + V_FRONT + V_SYNC + V_BACK;

   // Last coordinate of each region; every FSM transition keys off one of these.
   localparam logic [9:0] H_ACT_END = 10'(H_VIDEO - 1);
   localparam logic [9:0] H_FP_END  = 10'(H_VIDEO + H_FRONT - 1);
   localparam logic [9:0] H_SY_END  = 10'(H_VIDEO + H_FRONT + H_SYNC - 1);
   localparam logic [9:0] H_LAST    = 10'(H_TOTAL - 1);
   localparam logic [9:0] V_ACT_END = 10'(V_VIDEO - 1);
   localparam logic [9:0] V_FP_END  = 10'(V_VIDEO + V_FRONT - 1);
   localparam logic [9:0] V_SY_END  = 10'(V_VIDEO + V_FRONT + V_SYNC - 1);
   localparam logic [9:0] V_LAST    = 10'(V_TOTAL - 1);

   localparam logic SYNC_ACT = (SYNC_POL != 0);

   typedef enum logic [1:0] {HS_ACTIVE, HS_FRONT, HS_SYNC, HS_BACK} h_state_t;
   typedef enum logic [1:0] {VS_ACTIVE, VS_FRONT, VS_SYNC, VS_BACK} v_state_t;

   h_state_t   h_state, h_nxt;
   v_state_t   v_state, v_nxt;
   logic [9:0] x_nxt, y_nxt;
   logic       line_end;
   logic       frame_end;
   logic       hsync_raw;
   logic       vsync_raw;

   // Horizontal next-state: walk the four line regions, wrap x at the end of the line.
   always_comb begin
      h_nxt    = h_state;
      x_nxt    = pixel_x + 10'd1;
      line_end = (pixel_x == H_LAST);
      case (h_state)
         HS_ACTIVE: if (pixel_x == H_ACT_END) h_nxt = HS_FRONT;
         HS_FRONT:  if (pixel_x == H_FP_END)  h_nxt = HS_SYNC;
         HS_SYNC:   if (pixel_x == H_SY_END)  h_nxt = HS_BACK;
         default:   if (line_end)             h_nxt = HS_ACTIVE;
      endcase
      if (line_end) x_nxt = '0;
   end

   // Vertical next-state: only moves on the cycle the line wraps.
   always_comb begin
      v_nxt     = v_state;
      y_nxt     = pixel_y;
      frame_end = line_end && (pixel_y == V_LAST);
      if (line_end) begin
         y_nxt = frame_end ? 10'd0 : pixel_y + 10'd1;
         case (v_state)
            VS_ACTIVE: if (pixel_y == V_ACT_END) v_nxt = VS_FRONT;
            VS_FRONT:  if (pixel_y == V_FP_END)  v_nxt = VS_SYNC;
            VS_SYNC:   if (pixel_y == V_SY_END)  v_nxt = VS_BACK;
            default:   if (frame_end)            v_nxt = VS_ACTIVE;
         endcase
      end
   end

   // Position and FSM state registers; reset parks on the last pixel so the first edge lands on (0,0).
   always_ff @(posedge clk_0 or negedge rst) begin
      if (!rst) begin
         pixel_x <= H_LAST;
         pixel_y <= V_LAST;
         h_state <= HS_BACK;
         v_state <= VS_BACK;
      end else begin
         pixel_x <= x_nxt;
         pixel_y <= y_nxt;
         h_state <= h_nxt;
         v_state <= v_nxt;
      end
   end

   // Decodes of the next position, registered so they change on the same edge as pixel_x/pixel_y.
   always_ff @(posedge clk_0 or negedge rst) begin
      if (!rst) begin
         video_on    <= 1'b0;
         line_start  <= 1'b0;
         frame_start <= 1'b0;
         frame_count <= 8'd0;
      end else begin
         video_on    <= (h_nxt == HS_ACTIVE) && (v_nxt == VS_ACTIVE);
         line_start  <= line_end;
         frame_start <= frame_end;
         if (frame_end) frame_count <= frame_count + 8'd1;
      end
   end

   // Raw sync comes straight off the state registers, so it cannot glitch.
   assign hsync_raw = (h_state == HS_SYNC) ? SYNC_ACT : ~SYNC_ACT;
   assign vsync_raw = (v_state == VS_SYNC) ? SYNC_ACT : ~SYNC_ACT;

   generate
      if (SYNC_DELAY == 0) begin : g_no_delay
         assign hsync = hsync_raw;
         assign vsync = vsync_raw;
      end else begin : g_delay
         logic [SYNC_DELAY-1:0] h_pipe;
         logic [SYNC_DELAY-1:0] v_pipe;

         // Delay pipe aligning sync with the renderer's registered colour; resets to inactive.
         always_ff @(posedge clk_0 or negedge rst) begin
            if (!rst) begin
               h_pipe <= {SYNC_DELAY{~SYNC_ACT}};
               v_pipe <= {SYNC_DELAY{~SYNC_ACT}};
            end else begin
               h_pipe[0] <= hsync_raw;
               v_pipe[0] <= vsync_raw;
               for (int i = 1; i < SYNC_DELAY; i++) begin
                  h_pipe[i] <= h_pipe[i-1];
                  v_pipe[i] <= v_pipe[i-1];
               end
            end
         end

         assign hsync = h_pipe[SYNC_DELAY-1];
         assign vsync = v_pipe[SYNC_DELAY-1];
      end
   endgenerate

endmodule

// File: tb/tb_vga_sync_gen.sv
// Bench for vga_sync_gen: full-size instance for reset and line timing,
// reduced-size instance (16x10 raster, active-high sync, delay 2) for frame-level behaviour.
// Outputs are sampled on the falling edge of clk_0.
module tb_vga_sync_gen;

   logic clk_0 = 1'b0;
   always #20 clk_0 = ~clk_0;

   logic       rst_f, rst_s;
   logic [9:0] f_x, f_y, s_x, s_y;
   logic       f_von, f_ls, f_fs, f_hs, f_vs;
   logic       s_von, s_ls, s_fs, s_hs, s_vs;
   logic [7:0] f_fc, s_fc;

   int errors = 0;
   int checks = 0;

   // Scoreboards: line events (kind, cycle) and delayed sync levels.
   int ev_kind[$];
   int ev_cyc[$];
   bit sq_h[$];
   bit sq_v[$];

   vga_sync_gen dut_f (
      .clk_0(clk_0), .rst(rst_f), .pixel_x(f_x), .pixel_y(f_y), .video_on(f_von),
      .line_start(f_ls), .frame_start(f_fs), .frame_count(f_fc), .hsync(f_hs), .vsync(f_vs)
   );

   vga_sync_gen #(
      .H_VIDEO(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(3),
      .V_VIDEO(6), .V_FRONT(1), .V_SYNC(2), .V_BACK(1),
      .SYNC_POL(1), .SYNC_DELAY(2)
   ) dut_s (
      .clk_0(clk_0), .rst(rst_s), .pixel_x(s_x), .pixel_y(s_y), .video_on(s_von),
      .line_start(s_ls), .frame_start(s_fs), .frame_count(s_fc), .hsync(s_hs), .vsync(s_vs)
   );

   // Reset the small instance and leave the bench on the falling edge before its first active edge.
   task automatic restart_small();
      rst_s = 1'b0;
      repeat (3) @(negedge clk_0);
      rst_s = 1'b1;
   endtask

   task automatic test_reset();
      rst_f = 1'b0;
      rst_s = 1'b0;
      repeat (10) @(negedge clk_0);
      checks++; if (f_x !== 10'd799) begin errors++; $display("FAIL reset_x: got %0d want 799", f_x); end
      checks++; if (f_y !== 10'd524) begin errors++; $display("FAIL reset_y: got %0d want 524", f_y); end
      checks++; if (f_von !== 1'b0) begin errors++; $display("FAIL reset_video_on: got %b want 0", f_von); end
      checks++; if (f_ls !== 1'b0 || f_fs !== 1'b0) begin errors++; $display("FAIL reset_pulses: got ls=%b fs=%b want 0 0", f_ls, f_fs); end
      checks++; if (f_fc !== 8'd0) begin errors++; $display("FAIL reset_frame_count: got %0d want 0", f_fc); end
      checks++; if (f_hs !== 1'b1 || f_vs !== 1'b1) begin errors++; $display("FAIL reset_sync: got h=%b v=%b want 1 1", f_hs, f_vs); end
      checks++; if (s_x !== 10'd15 || s_y !== 10'd9) begin errors++; $display("FAIL reset_small_pos: got (%0d,%0d) want (15,9)", s_x, s_y); end
      checks++; if (s_hs !== 1'b0 || s_vs !== 1'b0) begin errors++; $display("FAIL reset_small_sync: got h=%b v=%b want 0 0", s_hs, s_vs); end
      rst_f = 1'b1;
      rst_s = 1'b1;
      @(negedge clk_0);
      checks++; if (f_x !== 10'd0 || f_y !== 10'd0) begin errors++; $display("FAIL first_pos: got (%0d,%0d) want (0,0)", f_x, f_y); end
      checks++; if (f_von !== 1'b1 || f_ls !== 1'b1 || f_fs !== 1'b1) begin errors++; $display("FAIL first_flags: got von=%b ls=%b fs=%b want 1 1 1", f_von, f_ls, f_fs); end
      checks++; if (f_fc !== 8'd1) begin errors++; $display("FAIL first_frame_count: got %0d want 1", f_fc); end
   endtask

   // Full-size line timing. Entered with dut_f sitting on cycle 0 (position (0,0)).
   task automatic test_line_timing();
      int von_cnt = 0;
      int hs_cnt  = 0;
      logic p_von = 1'b0;
      logic p_hs  = 1'b1;
      int obs[$];
      ev_kind.delete(); ev_cyc.delete();
      ev_kind.push_back(0); ev_cyc.push_back(0);
      for (int c = 0; c <= 1700; c++) begin
         if (c > 0) @(negedge clk_0);
         obs.delete();
         if (f_ls) obs.push_back(0);
         if (p_von && !f_von) obs.push_back(1);
         if (p_hs && !f_hs) obs.push_back(2);
         if (!p_hs && f_hs) obs.push_back(3);
         foreach (obs[i]) begin
            checks++;
            if (ev_kind.size() == 0) begin
               errors++; $display("FAIL line_event: got kind %0d at cycle %0d, want nothing pending", obs[i], c);
            end else begin
               int ke = ev_kind.pop_front();
               int ce = ev_cyc.pop_front();
               if (ke !== obs[i] || ce !== c) begin
                  errors++; $display("FAIL line_event: got kind %0d at cycle %0d, want kind %0d at cycle %0d", obs[i], c, ke, ce);
               end
            end
            if (obs[i] == 0) begin
               if (c > 0) begin
                  checks++; if (von_cnt !== 640) begin errors++; $display("FAIL line_video_on_count: got %0d want 640", von_cnt); end
                  checks++; if (hs_cnt !== 96) begin errors++; $display("FAIL line_hsync_width: got %0d want 96", hs_cnt); end
               end
               von_cnt = 0; hs_cnt = 0;
               ev_kind.push_back(1); ev_cyc.push_back(c + 640);
               ev_kind.push_back(2); ev_cyc.push_back(c + 657);
               ev_kind.push_back(3); ev_cyc.push_back(c + 753);
               ev_kind.push_back(0); ev_cyc.push_back(c + 800);
            end
         end
         von_cnt += int'(f_von);
         hs_cnt  += int'(!f_hs);
         p_von = f_von;
         p_hs  = f_hs;
      end
      checks++;
      if (ev_cyc.size() == 0 || ev_cyc[0] <= 1700) begin
         errors++; $display("FAIL line_missed_event: got pending cycle %0d want > 1700", (ev_cyc.size() == 0) ? -1 : ev_cyc[0]);
      end
   endtask

   // Reduced-size, two frames, every output compared against an arithmetic raster model.
   task automatic test_frame_model();
      int von_tot = 0;
      int vs_tot  = 0;
      sq_h.delete(); sq_v.delete();
      sq_h.push_back(1'b0); sq_h.push_back(1'b0);
      sq_v.push_back(1'b0); sq_v.push_back(1'b0);
      restart_small();
      for (int n = 0; n < 340; n++) begin
         int  mx, my, efc;
         bit  evon, eh, ev;
         @(negedge clk_0);
         mx   = n % 16;
         my   = (n / 16) % 10;
         efc  = (n / 160 + 1) % 256;
         evon = (mx < 8) && (my < 6);
         sq_h.push_back(mx >= 10 && mx <= 12);
         sq_v.push_back(my >= 7 && my <= 8);
         eh = sq_h.pop_front();
         ev = sq_v.pop_front();
         checks++; if (s_x !== 10'(mx) || s_y !== 10'(my)) begin errors++; $display("FAIL model_pos n=%0d: got (%0d,%0d) want (%0d,%0d)", n, s_x, s_y, mx, my); end
         checks++; if (s_von !== evon) begin errors++; $display("FAIL model_video_on n=%0d: got %b want %b", n, s_von, evon); end
         checks++; if (s_ls !== (mx == 0)) begin errors++; $display("FAIL model_line_start n=%0d: got %b want %b", n, s_ls, mx == 0); end
         checks++; if (s_fs !== (mx == 0 && my == 0)) begin errors++; $display("FAIL model_frame_start n=%0d: got %b want %b", n, s_fs, mx == 0 && my == 0); end
         checks++; if (s_fc !== 8'(efc)) begin errors++; $display("FAIL model_frame_count n=%0d: got %0d want %0d", n, s_fc, efc); end
         checks++; if (s_hs !== eh) begin errors++; $display("FAIL model_hsync n=%0d: got %b want %b", n, s_hs, eh); end
         checks++; if (s_vs !== ev) begin errors++; $display("FAIL model_vsync n=%0d: got %b want %b", n, s_vs, ev); end
         if (n < 160) von_tot += int'(s_von);
         if (n < 320) vs_tot += int'(s_vs);
      end
      checks++; if (von_tot !== 48) begin errors++; $display("FAIL frame_video_on_count: got %0d want 48", von_tot); end
      checks++; if (vs_tot !== 64) begin errors++; $display("FAIL frame_vsync_count: got %0d want 64", vs_tot); end
   endtask

   task automatic test_wrap();
      restart_small();
      for (int n = 0; n <= 160; n++) begin
         @(negedge clk_0);
         if (n == 95) begin
            checks++; if (s_x !== 10'd15 || s_y !== 10'd5) begin errors++; $display("FAIL wrap_pre_blank: got (%0d,%0d) want (15,5)", s_x, s_y); end
         end
         if (n == 96) begin
            checks++; if (s_x !== 10'd0 || s_y !== 10'd6 || s_von !== 1'b0) begin errors++; $display("FAIL wrap_blank: got (%0d,%0d) von=%b want (0,6) von=0", s_x, s_y, s_von); end
         end
         if (n == 159) begin
            checks++; if (s_x !== 10'd15 || s_y !== 10'd9) begin errors++; $display("FAIL wrap_pre_frame: got (%0d,%0d) want (15,9)", s_x, s_y); end
         end
         if (n == 160) begin
            checks++; if (s_x !== 10'd0 || s_y !== 10'd0 || s_fs !== 1'b1 || s_fc !== 8'd2) begin errors++; $display("FAIL wrap_frame: got (%0d,%0d) fs=%b fc=%0d want (0,0) fs=1 fc=2", s_x, s_y, s_fs, s_fc); end
         end
      end
   endtask

   task automatic test_frame_count();
      restart_small();
      for (int n = 0; n <= 256 * 160; n++) begin
         @(negedge clk_0);
         if (n == 254 * 160 - 1) begin
            checks++; if (s_fc !== 8'd254) begin errors++; $display("FAIL fc_254: got %0d want 254", s_fc); end
         end
         if (n == 254 * 160) begin
            checks++; if (s_fc !== 8'd255) begin errors++; $display("FAIL fc_255: got %0d want 255", s_fc); end
         end
         if (n == 255 * 160 - 1) begin
            checks++; if (s_fc !== 8'd255) begin errors++; $display("FAIL fc_hold_255: got %0d want 255", s_fc); end
         end
         if (n == 255 * 160) begin
            checks++; if (s_fc !== 8'd0) begin errors++; $display("FAIL fc_wrap: got %0d want 0", s_fc); end
         end
         if (n == 256 * 160) begin
            checks++; if (s_fc !== 8'd1) begin errors++; $display("FAIL fc_after_wrap: got %0d want 1", s_fc); end
         end
      end
   endtask

   task automatic test_mid_reset();
      // Full-size: reset mid-line while hsync is active.
      rst_f = 1'b0;
      repeat (3) @(negedge clk_0);
      rst_f = 1'b1;
      for (int n = 0; n <= 700; n++) @(negedge clk_0);
      checks++; if (f_x !== 10'd700 || f_hs !== 1'b0) begin errors++; $display("FAIL midrst_f_pre: got x=%0d h=%b want x=700 h=0", f_x, f_hs); end
      #5 rst_f = 1'b0;
      #1;
      checks++; if (f_hs !== 1'b1 || f_vs !== 1'b1) begin errors++; $display("FAIL midrst_f_sync: got h=%b v=%b want 1 1", f_hs, f_vs); end
      checks++; if (f_x !== 10'd799 || f_y !== 10'd524 || f_fc !== 8'd0) begin errors++; $display("FAIL midrst_f_state: got (%0d,%0d) fc=%0d want (799,524) fc=0", f_x, f_y, f_fc); end
      repeat (10) @(negedge clk_0);
      rst_f = 1'b1;
      @(negedge clk_0);
      checks++; if (f_x !== 10'd0 || f_y !== 10'd0 || f_von !== 1'b1 || f_fs !== 1'b1 || f_fc !== 8'd1) begin errors++; $display("FAIL midrst_f_restart: got (%0d,%0d) von=%b fs=%b fc=%0d want (0,0) 1 1 1", f_x, f_y, f_von, f_fs, f_fc); end
      // Small: reset while both syncs are active.
      restart_small();
      for (int n = 0; n <= 140; n++) @(negedge clk_0);
      checks++; if (s_hs !== 1'b1 || s_vs !== 1'b1) begin errors++; $display("FAIL midrst_s_pre: got h=%b v=%b want 1 1", s_hs, s_vs); end
      #5 rst_s = 1'b0;
      #1;
      checks++; if (s_hs !== 1'b0 || s_vs !== 1'b0) begin errors++; $display("FAIL midrst_s_sync: got h=%b v=%b want 0 0", s_hs, s_vs); end
      checks++; if (s_x !== 10'd15 || s_y !== 10'd9 || s_von !== 1'b0 || s_fc !== 8'd0) begin errors++; $display("FAIL midrst_s_state: got (%0d,%0d) von=%b fc=%0d want (15,9) 0 0", s_x, s_y, s_von, s_fc); end
      repeat (10) @(negedge clk_0);
      rst_s = 1'b1;
      @(negedge clk_0);
      checks++; if (s_x !== 10'd0 || s_y !== 10'd0 || s_fs !== 1'b1 || s_fc !== 8'd1 || s_hs !== 1'b0) begin errors++; $display("FAIL midrst_s_restart: got (%0d,%0d) fs=%b fc=%0d h=%b want (0,0) 1 1 0", s_x, s_y, s_fs, s_fc, s_hs); end
   endtask

   initial begin
      test_reset();
      test_line_timing();
      test_frame_model();
      test_wrap();
      test_frame_count();
      test_mid_reset();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
